// File: rtl/seq_div16_if.sv
// Start/busy/done handshake and operand/result bus for the sequential divider.
interface seq_div16_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             divzero;

   modport master (
      output start, a, b,
      input  quotient, remainder, busy, done, divzero
   );

   modport slave (
      input  start, a, b,
      output quotient, remainder, busy, done, divzero
   );
endinterface

// File: rtl/seq_div16.sv
// Iterative unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero flagged with a 1-cycle result.
module seq_div16 #(
   parameter int WIDTH = 16
) (
   input logic        clk,
   input logic        reset,
   seq_div16_if.slave dif
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r, state_s;
   // After each restore the partial remainder is below the divisor, so its
   // stored form never needs the extra bit; only the shifted trial value does.
   logic [WIDTH-1:0] rem_r, rem_s;
   logic [WIDTH-1:0] wq_r, wq_s;
   logic [WIDTH-1:0] div_r, div_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [WIDTH-1:0] quotient_r, quotient_s;
   logic [WIDTH-1:0] remainder_r, remainder_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic             divzero_r, divzero_s;
   logic [WIDTH:0]   shift_s;
   logic [WIDTH:0]   trial_s;

   assign shift_s = {rem_r, wq_r[WIDTH-1]};
   assign trial_s = shift_s - {1'b0, div_r};

   assign dif.quotient  = quotient_r;
   assign dif.remainder = remainder_r;
   assign dif.busy      = busy_r;
   assign dif.done      = done_r;
   assign dif.divzero   = divzero_r;

   // State, working and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         rem_r       <= {WIDTH{1'b0}};
         wq_r        <= {WIDTH{1'b0}};
         div_r       <= {WIDTH{1'b0}};
         cnt_r       <= {CW{1'b0}};
         quotient_r  <= {WIDTH{1'b0}};
         remainder_r <= {WIDTH{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         divzero_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         rem_r       <= rem_s;
         wq_r        <= wq_s;
         div_r       <= div_s;
         cnt_r       <= cnt_s;
         quotient_r  <= quotient_s;
         remainder_r <= remainder_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         divzero_r   <= divzero_s;
      end
   end

   // Next-state, iteration step and result capture
   always_comb begin
      state_s     = state_r;
      rem_s       = rem_r;
      wq_s        = wq_r;
      div_s       = div_r;
      cnt_s       = cnt_r;
      quotient_s  = quotient_r;
      remainder_s = remainder_r;
      busy_s      = busy_r;
      done_s      = 1'b0;
      divzero_s   = divzero_r;

      case (state_r)
         IDLE, DONE: begin
            if (dif.start) begin
               if (dif.b != {WIDTH{1'b0}}) begin
                  state_s = RUN;
                  wq_s    = dif.a;
                  div_s   = dif.b;
                  rem_s   = {WIDTH{1'b0}};
                  cnt_s   = {CW{1'b0}};
                  busy_s  = 1'b1;
               end else begin
                  state_s     = DONE;
                  quotient_s  = {WIDTH{1'b1}};
                  remainder_s = dif.a;
                  divzero_s   = 1'b1;
                  done_s      = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (!trial_s[WIDTH]) begin
               rem_s = trial_s[WIDTH-1:0];
               wq_s  = {wq_r[WIDTH-2:0], 1'b1};
            end else begin
               rem_s = shift_s[WIDTH-1:0];
               wq_s  = {wq_r[WIDTH-2:0], 1'b0};
            end
            if (cnt_r == CW'(WIDTH - 1)) begin
               state_s     = DONE;
               cnt_s       = {CW{1'b0}};
               quotient_s  = wq_s;
               remainder_s = rem_s;
               divzero_s   = 1'b0;
               busy_s      = 1'b0;
               done_s      = 1'b1;
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_seq_div16.sv
// Directed and randomised checks of seq_div16 against hand-computed results.
module tb_seq_div16;
   logic clk;
   logic reset;
   int   check_cnt;
   int   error_cnt;

   int          first_done, ndone, busy_cyc;
   logic        busy_at_done, dz_at;
   logic [15:0] q_at, r_at, q_mid, r_mid;
   logic [15:0] av, bv;

   seq_div16_if #(.WIDTH(16)) dif ();

   seq_div16 #(.WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .dif   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         error_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge; issues one operation and watches 20 cycles.
   task automatic run_op(input logic [15:0] opa, input logic [15:0] opb, input int pulse_i);
      dif.start = 1'b1;
      dif.a     = opa;
      dif.b     = opb;
      @(posedge clk); #1;
      dif.start = 1'b0;
      dif.a     = 16'($urandom);
      dif.b     = 16'($urandom);
      first_done = -1; ndone = 0; busy_cyc = 0; busy_at_done = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 8) begin
            q_mid = dif.quotient;
            r_mid = dif.remainder;
         end
         if (dif.done) begin
            ndone++;
            if (first_done < 0) begin
               first_done   = i;
               q_at         = dif.quotient;
               r_at         = dif.remainder;
               dz_at        = dif.divzero;
               busy_at_done = dif.busy;
            end
         end
         if (dif.busy) busy_cyc++;
         if (i == pulse_i) begin
            dif.start = 1'b1; dif.a = 16'd1; dif.b = 16'd1;
         end else begin
            dif.start = 1'b0;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic check_op(input string tag, input logic [15:0] eq, input logic [15:0] er,
                           input logic edz, input int elat, input int ebusy);
      check({tag, "_lat"}, first_done, elat);
      check({tag, "_ndone"}, ndone, 1);
      check({tag, "_busycyc"}, busy_cyc, ebusy);
      check({tag, "_busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
      check({tag, "_q"}, {16'd0, q_at}, {16'd0, eq});
      check({tag, "_r"}, {16'd0, r_at}, {16'd0, er});
      check({tag, "_dz"}, {31'd0, dz_at}, {31'd0, edz});
   endtask

   initial begin
      check_cnt = 0;
      error_cnt = 0;
      reset     = 1'b1;
      dif.start = 1'b0;
      dif.a     = 16'd0;
      dif.b     = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q", {16'd0, dif.quotient}, 32'd0);
      check("rst_r", {16'd0, dif.remainder}, 32'd0);
      check("rst_busy", {31'd0, dif.busy}, 32'd0);
      check("rst_done", {31'd0, dif.done}, 32'd0);
      check("rst_dz", {31'd0, dif.divzero}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_op(16'd100, 16'd7, -1);          check_op("d100_7", 16'd14, 16'd2, 1'b0, 16, 16);
      run_op(16'hFFFF, 16'd1, -1);         check_op("dffff_1", 16'hFFFF, 16'd0, 1'b0, 16, 16);
      run_op(16'd3, 16'd10, -1);           check_op("d3_10", 16'd0, 16'd3, 1'b0, 16, 16);
      run_op(16'hFFFF, 16'hFFFF, -1);      check_op("dffff_ffff", 16'd1, 16'd0, 1'b0, 16, 16);
      run_op(16'd5, 16'd0, -1);            check_op("d5_0", 16'hFFFF, 16'd5, 1'b1, 0, 0);
      run_op(16'd9, 16'd3, -1);            check_op("d9_3", 16'd3, 16'd0, 1'b0, 16, 16);
      check("d9_3_held_q", {16'd0, q_mid}, 32'hFFFF);
      check("d9_3_held_r", {16'd0, r_mid}, 32'd5);
      run_op(16'd1000, 16'd33, 4);         check_op("ignored_start", 16'd30, 16'd10, 1'b0, 16, 16);

      // Abort a run with reset at its 8th cycle
      dif.start = 1'b1; dif.a = 16'd50000; dif.b = 16'd123;
      @(posedge clk); #1;
      dif.start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      check("abort_q", {16'd0, dif.quotient}, 32'd0);
      check("abort_r", {16'd0, dif.remainder}, 32'd0);
      check("abort_busy", {31'd0, dif.busy}, 32'd0);
      check("abort_done", {31'd0, dif.done}, 32'd0);
      check("abort_dz", {31'd0, dif.divzero}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      ndone = 0; busy_cyc = 0;
      for (int i = 0; i < 20; i++) begin
         if (dif.done) ndone++;
         if (dif.busy) busy_cyc++;
         @(posedge clk); #1;
      end
      check("abort_no_done", ndone, 0);
      check("abort_no_busy", busy_cyc, 0);
      run_op(16'd50000, 16'd123, -1);      check_op("d50000_123", 16'd406, 16'd62, 1'b0, 16, 16);

      // Back-to-back: new start issued during the done cycle of the previous op
      dif.start = 1'b1; dif.a = 16'd100; dif.b = 16'd7;
      @(posedge clk); #1;
      dif.start = 1'b0;
      for (int i = 0; i < 30 && !dif.done; i++) begin
         @(posedge clk); #1;
      end
      check("b2b_first_done", {31'd0, dif.done}, 32'd1);
      run_op(16'd200, 16'd9, -1);          check_op("b2b_200_9", 16'd22, 16'd2, 1'b0, 16, 16);
      check("b2b_held_q", {16'd0, q_mid}, 32'd14);
      check("b2b_held_r", {16'd0, r_mid}, 32'd2);

      for (int n = 0; n < 1000; n++) begin
         av = 16'($urandom);
         bv = 16'($urandom_range(1, 65535));
         if (n % 4 == 1) bv = 16'($urandom_range(1, 255));
         run_op(av, bv, -1);
         check("rnd_lat", first_done, 16);
         check("rnd_q", {16'd0, q_at}, {16'd0, av / bv});
         check("rnd_r", {16'd0, r_at}, {16'd0, av % bv});
         check("rnd_inv", {16'd0, q_at} * {16'd0, bv} + {16'd0, r_at}, {16'd0, av});
         check("rnd_r_lt_b", {31'd0, (r_at < bv)}, 32'd1);
         check("rnd_dz", {31'd0, dz_at}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
      $finish;
   end
endmodule
